// File: rtl/lstm_pkg.sv
// Shared constants and saturation helpers for the LSTM datapath
// (multiplier-array reduction and gate activation).
package lstm_pkg;
  localparam int WL_DEF = 16;
  localparam int LANES  = 16;

  function automatic logic signed [63:0] sat_max(input int wl);
    return (64'sd1 <<< (wl - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_min(input int wl);
    return -(64'sd1 <<< (wl - 1));
  endfunction

  // Clamp a wide signed value into wl bits; sat flags a clamp.
  function automatic logic signed [63:0] sat_to_wl(input logic signed [63:0] x,
                                                   input int wl,
                                                   output logic sat);
    logic signed [63:0] r;
    sat = 1'b1;
    if (x > sat_max(wl)) begin
      r = sat_max(wl);
    end else if (x < sat_min(wl)) begin
      r = sat_min(wl);
    end else begin
      r   = x;
      sat = 1'b0;
    end
    return r;
  endfunction
endpackage

// File: rtl/mult_array_accum_if.sv
// Product stream from the multiplier array and reduced result towards activation.
interface mult_array_accum_if import lstm_pkg::*; #(
  parameter int WL = WL_DEF
);
  logic                  flush;
  logic                  in_valid;
  logic                  in_last;
  logic [LANES*WL-1:0]   prod_in;
  logic                  out_valid;
  logic [WL-1:0]         out_data;
  logic                  out_sat;
  logic                  busy;

  modport master (
    output flush, in_valid, in_last, prod_in,
    input  out_valid, out_data, out_sat, busy
  );

  modport slave (
    input  flush, in_valid, in_last, prod_in,
    output out_valid, out_data, out_sat, busy
  );
endinterface

// File: rtl/add_tree_16.sv
// Four-level registered pairwise adder over 16 signed lanes, growing one bit
// per level so nothing is ever truncated; valid/last ride alongside.
module add_tree_16 import lstm_pkg::*; #(
  parameter int WL = WL_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic [LANES*WL-1:0]    prod,
  output logic signed [WL+3:0]   sum,
  output logic                   sum_valid,
  output logic                   sum_last,
  output logic                   any_valid
);
  logic signed [WL:0]   l1 [LANES/2];
  logic signed [WL+1:0] l2 [LANES/4];
  logic signed [WL+2:0] l3 [LANES/8];
  logic [3:0]           vld;
  logic [3:0]           lst;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      lst <= '0;
      for (int i = 0; i < LANES/2; i++) l1[i] <= '0;
      for (int i = 0; i < LANES/4; i++) l2[i] <= '0;
      for (int i = 0; i < LANES/8; i++) l3[i] <= '0;
      sum <= '0;
    end else begin
      // Data is left to flow during flush; only the valids matter downstream.
      vld <= flush ? 4'b0 : {vld[2:0], in_valid};
      lst <= flush ? 4'b0 : {lst[2:0], in_last};
      for (int i = 0; i < LANES/2; i++)
        l1[i] <= (WL+1)'($signed(prod[2*i*WL +: WL]))
               + (WL+1)'($signed(prod[(2*i+1)*WL +: WL]));
      for (int i = 0; i < LANES/4; i++)
        l2[i] <= (WL+2)'(l1[2*i]) + (WL+2)'(l1[2*i+1]);
      for (int i = 0; i < LANES/8; i++)
        l3[i] <= (WL+3)'(l2[2*i]) + (WL+3)'(l2[2*i+1]);
      sum <= (WL+4)'(l3[0]) + (WL+4)'(l3[1]);
    end
  end

  assign sum_valid = vld[3];
  assign sum_last  = lst[3];
  assign any_valid = |vld;
endmodule

// File: rtl/mult_array_accum.sv
// Row reduction for the matrix-vector product: registers the product beat, sums
// it through add_tree_16, accumulates beats and emits one saturated result per vector.
module mult_array_accum import lstm_pkg::*; #(
  parameter int WL        = WL_DEF,
  parameter int MAX_BEATS = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  mult_array_accum_if.slave bus
);
  localparam int ACC_W = WL + 4 + $clog2(MAX_BEATS);

  logic                     in_v;
  logic                     in_l;
  logic [LANES*WL-1:0]      in_prod;
  logic signed [WL+3:0]     t_sum;
  logic                     t_valid;
  logic                     t_last;
  logic                     t_busy;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  opnd;
  logic signed [ACC_W-1:0]  sum;
  logic                     first;
  logic [WL-1:0]            sat_val;
  logic                     sat_nxt;
  logic                     out_valid;
  logic [WL-1:0]            out_data;
  logic                     out_sat;

  add_tree_16 #(.WL(WL)) u_tree (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (bus.flush),
    .in_valid  (in_v),
    .in_last   (in_l),
    .prod      (in_prod),
    .sum       (t_sum),
    .sum_valid (t_valid),
    .sum_last  (t_last),
    .any_valid (t_busy)
  );

  always_comb begin
    sat_nxt = 1'b0;
    opnd    = first ? '0 : acc;
    sum     = opnd + ACC_W'(t_sum);
    sat_val = WL'(sat_to_wl(64'(sum), WL, sat_nxt));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_v      <= 1'b0;
      in_l      <= 1'b0;
      in_prod   <= '0;
      acc       <= '0;
      first     <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (bus.flush) begin
      in_v      <= 1'b0;
      in_l      <= 1'b0;
      acc       <= '0;
      first     <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      in_v      <= bus.in_valid;
      in_l      <= bus.in_valid & bus.in_last;
      in_prod   <= bus.prod_in;
      out_valid <= 1'b0;
      if (t_valid) begin
        if (t_last) begin
          out_data  <= sat_val;
          out_sat   <= sat_nxt;
          out_valid <= 1'b1;
          acc       <= '0;
          first     <= 1'b1;
        end else begin
          acc       <= sum;
          first     <= 1'b0;
        end
      end
    end
  end

  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_sat   = out_sat;
  assign bus.busy      = in_v | t_busy | ~first;
endmodule

// File: tb/tb_mult_array_accum.sv
// Directed bench for mult_array_accum: hand-computed dot products, latency,
// saturation, gaps, flush and mid-vector reset.
module tb_mult_array_accum;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic        sat;
  } pulse_t;
  pulse_t pq[$];

  mult_array_accum_if ifc ();

  mult_array_accum dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (ifc.out_valid === 1'b1) pq.push_back('{cyc, ifc.out_data, ifc.out_sat});

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic v, input logic l, input logic [15:0] val, output int t);
    ifc.in_valid = v;
    ifc.in_last  = l;
    ifc.prod_in  = {16{val}};
    @(posedge clk);
    #1;
    t = cyc;
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_pulse(input string tag, input int t_exp,
                             input logic [15:0] d_exp, input logic s_exp);
    pulse_t p;
    chk({tag, "_present"}, 32'(pq.size() != 0), 32'd1);
    if (pq.size() != 0) begin
      p = pq.pop_front();
      chk({tag, "_cycle"}, 32'(p.cyc), 32'(t_exp));
      chk({tag, "_data"},  32'(p.data), 32'(d_exp));
      chk({tag, "_sat"},   32'(p.sat), 32'(s_exp));
    end
  endtask

  initial begin
    int t, ta, tb;
    ifc.flush    = 1'b0;
    ifc.in_valid = 1'b0;
    ifc.in_last  = 1'b0;
    ifc.prod_in  = '0;

    // Reset state
    idle(2);
    chk("rst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("rst_out_data",  32'(ifc.out_data),  32'd0);
    chk("rst_out_sat",   32'(ifc.out_sat),   32'd0);
    chk("rst_busy",      32'(ifc.busy),      32'd0);
    rst_n = 1'b1;
    idle(1);

    // Reset in the middle of a vector
    beat(1'b1, 1'b0, 16'h0005, t);
    beat(1'b1, 1'b0, 16'h0005, t);
    idle(1);
    chk("mid_busy", 32'(ifc.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(ifc.out_valid), 32'd0);
    chk("midrst_out_data",  32'(ifc.out_data),  32'd0);
    chk("midrst_busy",      32'(ifc.busy),      32'd0);
    idle(2);
    rst_n = 1'b1;
    idle(1);

    // Single beat after reset: 16 * 1
    beat(1'b1, 1'b1, 16'h0001, t);
    idle(8);
    chk("single_count", 32'(pq.size()), 32'd1);
    check_pulse("single", t + 5, 16'h0010, 1'b0);

    // Back-to-back vectors: 3*16*2 = 96, then 16*(-1) = -16
    beat(1'b1, 1'b0, 16'h0002, t);
    beat(1'b1, 1'b0, 16'h0002, t);
    beat(1'b1, 1'b1, 16'h0002, ta);
    beat(1'b1, 1'b1, 16'hFFFF, tb);
    idle(8);
    chk("b2b_count", 32'(pq.size()), 32'd2);
    check_pulse("vecA", ta + 5, 16'h0060, 1'b0);
    check_pulse("vecB", ta + 6, 16'hFFF0, 1'b0);

    // Positive overflow: 4*16*32767
    beat(1'b1, 1'b0, 16'h7FFF, t);
    beat(1'b1, 1'b0, 16'h7FFF, t);
    beat(1'b1, 1'b0, 16'h7FFF, t);
    beat(1'b1, 1'b1, 16'h7FFF, t);
    idle(8);
    check_pulse("pos_ovf", t + 5, 16'h7FFF, 1'b1);

    // Negative overflow: 2*16*(-32768)
    beat(1'b1, 1'b0, 16'h8000, t);
    beat(1'b1, 1'b1, 16'h8000, t);
    idle(8);
    check_pulse("neg_ovf", t + 5, 16'h8000, 1'b1);

    // Gaps plus a stray in_last without in_valid: 4*16 = 64
    beat(1'b1, 1'b0, 16'h0001, t);
    idle(2);
    beat(1'b1, 1'b0, 16'h0001, t);
    beat(1'b0, 1'b1, 16'h0001, t);
    idle(1);
    beat(1'b1, 1'b0, 16'h0001, t);
    beat(1'b1, 1'b1, 16'h0001, t);
    idle(8);
    chk("gap_count", 32'(pq.size()), 32'd1);
    check_pulse("gaps", t + 5, 16'h0040, 1'b0);
    chk("hold_data", 32'(ifc.out_data), 32'h0040);
    chk("hold_valid", 32'(ifc.out_valid), 32'd0);

    // Flush mid-vector, beat presented with flush is dropped; then 16*3 = 48
    beat(1'b1, 1'b0, 16'h0001, t);
    beat(1'b1, 1'b0, 16'h0001, t);
    ifc.flush = 1'b1;
    beat(1'b1, 1'b1, 16'h0007, t);
    ifc.flush = 1'b0;
    chk("flush_busy", 32'(ifc.busy), 32'd0);
    beat(1'b1, 1'b1, 16'h0003, t);
    idle(8);
    chk("flush_count", 32'(pq.size()), 32'd1);
    check_pulse("flush", t + 5, 16'h0030, 1'b0);
    chk("final_busy", 32'(ifc.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/mult_array_accum.md
Name: mult_array_accum

Overview:
- Consumer side of the 16-lane multiplier array: reduces 16 WL-bit signed products per beat through a registered adder tree.
- Accumulates successive beats into one dot product and emits one saturated WL-bit result per vector.
- Sits between the multiplier array and the LSTM gate activation stage, i.e. the matrix-vector row reduction.
- Streaming, no backpressure: the multiplier array cannot stall.

Parameters:
- WL, 16: word length of products and result; signed two's complement, same fixed-point format in and out.
- LANES, 16: products per beat; fixed at 16, a power of two, 4 tree levels.
- MAX_BEATS, 64: maximum beats per vector; sets accumulator guard bits.
- ACC_W, WL+4+$clog2(MAX_BEATS): internal accumulator width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous clear of pipeline and accumulator
- in_valid  in  1  prod_in holds a valid beat, aligned to the multiplier output
- in_last  in  1  final beat of the current vector; qualified by in_valid
- prod_in  in  LANES*WL  products; lane i at bits [i*WL +: WL]
- out_valid  out  1  one-cycle pulse, result available
- out_data  out  WL  saturated dot product
- out_sat  out  1  saturation occurred on this result; qualified by out_valid
- busy  out  1  a vector is partially accumulated or beats are in the tree

Behaviour:
- Reset (rst_n low, asynchronous): all pipeline valid/last bits 0, accumulator 0, out_valid 0, out_data 0, out_sat 0, busy 0, first-beat flag 1.
- Tree: 4 registered levels, each adding adjacent pairs sign-extended by 1 bit: WL+1 -> WL+2 -> WL+3 -> WL+4. No truncation inside the tree. in_valid and in_last travel alongside in a 4-deep shift register.
- Accumulate stage, acting on the tree output when its valid is 1:
  - operand = 0 if the first-beat flag is 1, else the accumulator register.
  - sum = operand + sign-extended tree sum, ACC_W bits.
  - If last=0: the accumulator takes sum and the first-beat flag clears.
  - If last=1: out_data takes sat(sum) and out_valid=1. out_sat=1 if sum > 2^(WL-1)-1 (clamped to 0x7FFF for WL=16) or sum < -2^(WL-1) (clamped to 0x8000). The accumulator takes 0 and the first-beat flag sets.
- Latency: a beat sampled with in_valid&in_last at edge T gives out_valid high for exactly the cycle after edge T+5.
- Throughput: one beat per clock, back-to-back vectors allowed. The last beat of vector k may be followed directly by the first beat of vector k+1 with no bubble and no cross-contamination.
- Single-beat vector (in_valid&in_last on the first beat): the result is the saturated tree sum.
- Gaps (in_valid=0) between beats of a vector are allowed; the accumulator holds its value.
- in_last with in_valid=0 is ignored.
- out_valid otherwise 0. out_data and out_sat hold their last values when out_valid=0.
- flush=1 at an edge:
  - clears all pipeline valids, the accumulator and out_valid, and sets the first-beat flag.
  - A beat presented in the same cycle is discarded.
  - flush takes priority over every other update.
- Beats beyond MAX_BEATS without a last: the accumulator wraps, and this is not detected.
- busy = any tree valid bit | ~first-beat flag.

Decomposition:
- Shared package lstm_pkg holds:
  - the WL default,
  - the LANES constant,
  - the SAT_MAX and SAT_MIN functions of WL,
  - a sat_to_wl function (ACC_W -> WL clamp plus flag), reused by the activation stage.
- One sub-module, add_tree_16: the 4-level registered pairwise adder with valid/last sideband.
- Accumulator, saturation and flush logic stay in the top level.

Test Plan:
- Reset with rst_n low mid-vector -> out_valid=0, out_data=0, busy=0. The next vector after release is unaffected by pre-reset beats.
- Single beat, all lanes 0x0001, in_last=1 at edge T -> out_valid after edge T+5, out_data=0x0010, out_sat=0.
- Two vectors back-to-back:
  - vector A: 3 beats of all lanes 0x0002, last on beat 3 -> 0x0060.
  - vector B: 1 beat of all lanes 0xFFFF -> 0xFFF0 (-16).
  - Required: two pulses exactly 1 cycle apart, both out_sat=0.
- Positive overflow: 4 beats of all lanes 0x7FFF -> out_data=0x7FFF, out_sat=1. Negative: 2 beats of all lanes 0x8000 -> 0x8000, out_sat=1.
- Gaps: beats of 0x0001 with in_valid=0 cycles between them, 4 beats -> 0x0040. A stray in_last with in_valid=0 produces no pulse.
- flush asserted after 2 beats of a 4-beat vector, then a fresh single beat of all lanes 0x0003 -> only one pulse, out_data=0x0030, busy=0 afterwards.
